// File: rtl/dyser_recv_buffer.sv
// DySER output-side receive buffer: one small FIFO per fabric output port feeding two read lanes.
// Optional same-cycle fabric-to-lane forwarding is enabled by defining DYSER_RECV_BYPASS_EN.
module dyser_recv_buffer #(
  parameter int unsigned NUM_PORTS = 8,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned WIDTH     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS*WIDTH-1:0] fab_data,
  input  logic [NUM_PORTS-1:0]       fab_valid,
  output logic [NUM_PORTS-1:0]       fab_ready,
  input  logic [2:0]                 recv_port_r0,
  input  logic [2:0]                 recv_port_r1,
  input  logic                       recv_en0,
  input  logic                       recv_en1,
  output logic [WIDTH-1:0]           recv_data_r0,
  output logic [WIDTH-1:0]           recv_data_r1,
  output logic                       recv_stall,
  input  logic                       commit,
  output logic [NUM_PORTS*3-1:0]     occupancy
);

  localparam int unsigned PW = (DEPTH > 2) ? 2 : 1;

  logic [WIDTH-1:0] mem_q  [NUM_PORTS][DEPTH];
  logic [PW-1:0]    rptr_q [NUM_PORTS];
  logic [PW-1:0]    rptr_d [NUM_PORTS];
  logic [PW-1:0]    wptr_q [NUM_PORTS];
  logic [PW-1:0]    wptr_d [NUM_PORTS];
  logic [2:0]       cnt_q  [NUM_PORTS];
  logic [2:0]       cnt_d  [NUM_PORTS];
  logic [NUM_PORTS-1:0] push;

  logic [2:0]       cnt0, cnt1;
  logic             same, byp0, byp1, have0, have1, ok0, ok1, fire;
  logic [PW-1:0]    rd1_ptr;
  logic [WIDTH-1:0] head0, head1, fab0, fab1;

  always_comb begin
    cnt0    = cnt_q[recv_port_r0];
    cnt1    = cnt_q[recv_port_r1];
    same    = recv_en0 && recv_en1 && (recv_port_r0 == recv_port_r1);
    // A same-port dual read hands lane 1 the entry behind the head.
    rd1_ptr = same ? rptr_q[recv_port_r1] + PW'(1) : rptr_q[recv_port_r1];
    head0   = mem_q[recv_port_r0][rptr_q[recv_port_r0]];
    head1   = mem_q[recv_port_r1][rd1_ptr];
    fab0    = fab_data[int'(recv_port_r0)*WIDTH +: WIDTH];
    fab1    = fab_data[int'(recv_port_r1)*WIDTH +: WIDTH];
    have0   = (cnt0 != 3'd0);
    have1   = same ? (cnt1 >= 3'd2) : (cnt1 != 3'd0);
`ifdef DYSER_RECV_BYPASS_EN
    byp0 = recv_en0 && !same && (cnt0 == 3'd0) && fab_valid[recv_port_r0];
    byp1 = recv_en1 && fab_valid[recv_port_r1] &&
           (same ? (cnt1 == 3'd1) : (cnt1 == 3'd0));
`else
    byp0 = 1'b0;
    byp1 = 1'b0;
`endif
    ok0        = !recv_en0 || have0 || byp0;
    ok1        = !recv_en1 || have1 || byp1;
    recv_stall = !commit && !(ok0 && ok1);
    fire       = !commit && ok0 && ok1;

    recv_data_r0 = '0;
    if (recv_en0) begin
      if (have0)     recv_data_r0 = head0;
      else if (byp0) recv_data_r0 = fab0;
    end
    recv_data_r1 = '0;
    if (recv_en1) begin
      if (have1)     recv_data_r1 = head1;
      else if (byp1) recv_data_r1 = fab1;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      logic [2:0] pop_n;
      logic       bypassed;
      pop_n    = 3'd0;
      bypassed = 1'b0;
      fab_ready[p]        = (cnt_q[p] < 3'(DEPTH));
      occupancy[p*3 +: 3] = cnt_q[p];
      if (fire) begin
        if (recv_en0 && (recv_port_r0 == 3'(p)) && !byp0) pop_n = pop_n + 3'd1;
        if (recv_en1 && (recv_port_r1 == 3'(p)) && !byp1) pop_n = pop_n + 3'd1;
        bypassed = (byp0 && (recv_port_r0 == 3'(p))) || (byp1 && (recv_port_r1 == 3'(p)));
      end
      // A forwarded value is consumed directly, so it is never written.
      push[p] = fab_valid[p] && fab_ready[p] && !bypassed && !commit;
      if (commit) begin
        cnt_d[p]  = 3'd0;
        rptr_d[p] = '0;
        wptr_d[p] = '0;
      end else begin
        cnt_d[p]  = cnt_q[p] + {2'b00, push[p]} - pop_n;
        rptr_d[p] = rptr_q[p] + PW'(pop_n);
        wptr_d[p] = wptr_q[p] + PW'(push[p]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        cnt_q[p]  <= 3'd0;
        rptr_q[p] <= '0;
        wptr_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        cnt_q[p]  <= cnt_d[p];
        rptr_q[p] <= rptr_d[p];
        wptr_q[p] <= wptr_d[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push[p]) mem_q[p][wptr_q[p]] <= fab_data[p*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_dyser_recv_buffer.sv
// Directed bench for dyser_recv_buffer with a per-port scoreboard of expected read values.
module tb_dyser_recv_buffer;
  localparam int NP = 8;
  localparam int W  = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP*W-1:0] fab_data;
  logic [NP-1:0]   fab_valid;
  logic [NP-1:0]   fab_ready;
  logic [2:0]      recv_port_r0, recv_port_r1;
  logic            recv_en0, recv_en1;
  logic [W-1:0]    recv_data_r0, recv_data_r1;
  logic            recv_stall;
  logic            commit;
  logic [NP*3-1:0] occupancy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] mq[NP][$];

  dyser_recv_buffer dut (
    .clk(clk), .rst(rst), .fab_data(fab_data), .fab_valid(fab_valid), .fab_ready(fab_ready),
    .recv_port_r0(recv_port_r0), .recv_port_r1(recv_port_r1), .recv_en0(recv_en0),
    .recv_en1(recv_en1), .recv_data_r0(recv_data_r0), .recv_data_r1(recv_data_r1),
    .recv_stall(recv_stall), .commit(commit), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic push_val(input int p, input logic [W-1:0] v);
    fab_valid[p]       = 1'b1;
    fab_data[p*W +: W] = v;
    mq[p].push_back(v);
  endtask

  function automatic logic [W-1:0] pop_exp(input int p);
    if (mq[p].size() == 0) return '1;
    return mq[p].pop_front();
  endfunction

  function automatic logic [W-1:0] occ(input int p);
    return W'(occupancy[p*3 +: 3]);
  endfunction

  initial begin
    rst = 1'b1; fab_data = '0; fab_valid = '0; recv_port_r0 = '0; recv_port_r1 = '0;
    recv_en0 = 1'b0; recv_en1 = 1'b0; commit = 1'b0;
    #12;
    chk("reset_ready", W'(fab_ready), W'(8'hFF));
    chk("reset_occ", W'(occupancy), '0);
    chk("reset_stall", W'(recv_stall), '0);
    chk("reset_data0", recv_data_r0, '0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Basic two-lane read from different ports
    push_val(7, 64'h0); push_val(5, 64'h1);
    tick(); fab_valid = '0;
    recv_port_r0 = 3'd7; recv_port_r1 = 3'd5; recv_en0 = 1'b1; recv_en1 = 1'b1;
    settle();
    chk("basic_r0", recv_data_r0, pop_exp(7));
    chk("basic_r1", recv_data_r1, pop_exp(5));
    chk("basic_stall", W'(recv_stall), '0);
    tick(); recv_en0 = 1'b0; recv_en1 = 1'b0; settle();
    chk("basic_occ7", occ(7), '0);
    chk("basic_occ5", occ(5), '0);

    // Empty-port stall, released by a push
    recv_port_r0 = 3'd3; recv_en0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("empty_stall", W'(recv_stall), 64'd1); tick();
    end
    push_val(3, 64'h2);
`ifdef DYSER_RECV_BYPASS_EN
    settle();
    chk("byp_stall", W'(recv_stall), '0);
    chk("byp_data", recv_data_r0, pop_exp(3));
    tick(); fab_valid = '0; recv_en0 = 1'b0; settle();
`else
    settle();
    chk("push_cycle_stall", W'(recv_stall), 64'd1);
    tick(); fab_valid = '0; settle();
    chk("after_push_stall", W'(recv_stall), '0);
    chk("after_push_data", recv_data_r0, pop_exp(3));
    tick(); recv_en0 = 1'b0; settle();
`endif
    chk("empty_occ3", occ(3), '0);

    // Same-port dual read
    push_val(0, 64'h6); tick(); fab_valid = '0;
    push_val(0, 64'h7); tick(); fab_valid = '0;
    settle(); chk("dual_occ_full", occ(0), 64'd2);
    recv_port_r0 = 3'd0; recv_port_r1 = 3'd0; recv_en0 = 1'b1; recv_en1 = 1'b1;
    settle();
    chk("dual_r0", recv_data_r0, pop_exp(0));
    chk("dual_r1", recv_data_r1, pop_exp(0));
    chk("dual_stall", W'(recv_stall), '0);
    tick(); recv_en0 = 1'b0; recv_en1 = 1'b0; settle();
    chk("dual_occ_empty", occ(0), '0);
    push_val(0, 64'h8); tick(); fab_valid = '0;
    recv_en0 = 1'b1; recv_en1 = 1'b1; settle();
    chk("dual_one_stall", W'(recv_stall), 64'd1);
    tick(); settle();
    chk("dual_one_occ", occ(0), 64'd1);
    recv_en1 = 1'b0; settle();
    chk("single_stall", W'(recv_stall), '0);
    chk("single_data", recv_data_r0, pop_exp(0));
    tick(); recv_en0 = 1'b0;

    // Full port, pop while the fabric keeps offering a value, then wrap
    push_val(2, 64'hA); tick(); fab_valid = '0;
    push_val(2, 64'hB); tick(); fab_valid = '0;
    settle();
    chk("full_ready", W'(fab_ready[2]), '0);
    chk("full_occ", occ(2), 64'd2);
    fab_valid[2] = 1'b1; fab_data[2*W +: W] = 64'hC;
    recv_port_r0 = 3'd2; recv_en0 = 1'b1; settle();
    chk("full_pop_data", recv_data_r0, pop_exp(2));
    chk("full_pop_stall", W'(recv_stall), '0);
    tick(); recv_en0 = 1'b0; settle();
    chk("full_after_pop_occ", occ(2), 64'd1);
    chk("full_after_pop_ready", W'(fab_ready[2]), 64'd1);
    mq[2].push_back(64'hC);
    tick(); fab_valid = '0; settle();
    chk("wrap_occ", occ(2), 64'd2);
    recv_en0 = 1'b1; settle();
    chk("wrap_rd_b", recv_data_r0, pop_exp(2));
    tick(); settle();
    chk("wrap_rd_c", recv_data_r0, pop_exp(2));
    tick(); recv_en0 = 1'b0; settle();
    chk("wrap_occ_empty", occ(2), '0);

    // Atomic stall across lanes
    push_val(4, 64'h4); tick(); fab_valid = '0;
    recv_port_r0 = 3'd4; recv_port_r1 = 3'd1; recv_en0 = 1'b1; recv_en1 = 1'b1;
    settle(); chk("atomic_stall", W'(recv_stall), 64'd1);
    tick(); settle(); chk("atomic_occ4", occ(4), 64'd1);
    recv_en1 = 1'b0; settle();
    chk("atomic_drain", recv_data_r0, pop_exp(4));
    tick(); recv_en0 = 1'b0;

    // Commit flush
    for (int p = 0; p < NP; p++) push_val(p, W'(64'h10 + p));
    tick(); fab_valid = '0; settle();
    chk("fill_occ", W'(occupancy), W'(24'o11111111));
    commit = 1'b1; recv_port_r0 = 3'd0; recv_port_r1 = 3'd0;
    recv_en0 = 1'b1; recv_en1 = 1'b1; fab_valid[3] = 1'b1; settle();
    chk("commit_stall", W'(recv_stall), '0);
    tick(); commit = 1'b0; recv_en0 = 1'b0; recv_en1 = 1'b0; fab_valid = '0; settle();
    chk("commit_occ", W'(occupancy), '0);
    chk("commit_ready", W'(fab_ready), W'(8'hFF));
    for (int p = 0; p < NP; p++) mq[p].delete();

    // Asynchronous reset in mid-cycle
    push_val(6, 64'h66); tick(); fab_valid = '0;
    recv_port_r0 = 3'd6; recv_en0 = 1'b1; #1;
    chk("pre_rst_data", recv_data_r0, mq[6][0]);
    rst = 1'b1; #1;
    chk("rst_occ", W'(occupancy), '0);
    chk("rst_data", recv_data_r0, '0);
    chk("rst_ready", W'(fab_ready), W'(8'hFF));
    recv_en0 = 1'b0; #1;
    chk("rst_stall", W'(recv_stall), '0);
    mq[6].delete();
    @(negedge clk); rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
